// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the LUT configuration writer.
// Holds the FSM state encoding, depth helper and the order-sensitive checksum step.
package lut_cfg_pkg;

  localparam int unsigned DATA_WIDTH_DEF    = 4;
  localparam int unsigned CONTROL_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_FLUSH,
    S_READ,
    S_DRAIN,
    S_CHECK
  } state_t;

  function automatic int unsigned lut_depth(input int unsigned cw);
    return 32'd1 << cw;
  endfunction

  // rotl(chk, 1) ^ value, confined to the low 'width' bits
  function automatic logic [31:0] chk_update(input logic [31:0] chk,
                                             input logic [31:0] value,
                                             input int unsigned width);
    logic [31:0] mask;
    logic [31:0] rot;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    rot  = ((chk << 1) | ((chk & mask) >> (width - 1))) & mask;
    return rot ^ (value & mask);
  endfunction

endpackage

// File: rtl/lut_cfg_if.sv
// Configuration stream plus LUT memory port seen by the writer.
interface lut_cfg_if
  import lut_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned CONTROL_WIDTH = CONTROL_WIDTH_DEF
);
  logic                     cfg_valid;
  logic [DATA_WIDTH-1:0]    cfg_data;
  logic                     cfg_ready;
  logic                     mem_we;
  logic                     mem_re;
  logic [CONTROL_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  cfg_valid, cfg_data, mem_rdata,
    output cfg_ready, mem_we, mem_re, mem_addr, mem_wdata
  );

  modport master (
    output cfg_valid, cfg_data, mem_rdata,
    input  cfg_ready, mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lut_cfg_checksum.sv
// Clear/enable accumulator of the rotl-xor checksum.
module lut_cfg_checksum
  import lut_cfg_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] chk
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      chk <= '0;
    end else if (enable) begin
      chk <= WIDTH'(chk_update(32'(chk), 32'(data), WIDTH));
    end
  end

endmodule

// File: rtl/lut_cfg_writer.sv
// Loads DEPTH LUT entries from a valid/ready stream, reads them back and
// compares write/read checksums, reporting done and a sticky error.
module lut_cfg_writer
  import lut_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned CONTROL_WIDTH = CONTROL_WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  lut_cfg_if.slave               bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [CONTROL_WIDTH:0] count
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned CW    = CONTROL_WIDTH;
  localparam int unsigned DEPTH = lut_depth(CW);

  localparam logic [CW-1:0] LAST_ADDR  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ADDR_ONE   = CW'(1);
  localparam logic [CW:0]   FULL_COUNT = (CW + 1)'(DEPTH);
  localparam logic [CW:0]   COUNT_ONE  = (CW + 1)'(1);

  state_t          state, state_d;
  logic [CW-1:0]   wr_idx, wr_idx_d;
  logic [CW:0]     count_d;
  logic            error_d, done_d, busy_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_re_q, mem_re_d;
  logic [CW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            rd_valid;
  logic            cfg_ready_c, handshake_c, chk_clear_c;
  logic [DW-1:0]   wr_chk, rd_chk;

  assign cfg_ready_c   = (state == S_WRITE) && !abort;
  assign handshake_c   = cfg_ready_c && bus.cfg_valid;
  assign bus.cfg_ready = cfg_ready_c;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  lut_cfg_checksum #(.WIDTH(DW)) u_wr_chk (
    .clock (clock),
    .reset (reset),
    .clear (chk_clear_c),
    .enable(handshake_c),
    .data  (bus.cfg_data),
    .chk   (wr_chk)
  );

  lut_cfg_checksum #(.WIDTH(DW)) u_rd_chk (
    .clock (clock),
    .reset (reset),
    .clear (chk_clear_c),
    .enable(rd_valid),
    .data  (bus.mem_rdata),
    .chk   (rd_chk)
  );

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      wr_idx      <= '0;
      count       <= '0;
      error       <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_valid    <= 1'b0;
    end else begin
      state       <= state_d;
      wr_idx      <= wr_idx_d;
      count       <= count_d;
      error       <= error_d;
      done        <= done_d;
      busy        <= busy_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_valid    <= mem_re_q;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d     = state;
    wr_idx_d    = wr_idx;
    count_d     = count;
    error_d     = error;
    done_d      = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    chk_clear_c = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_WRITE;
          wr_idx_d    = '0;
          count_d     = '0;
          error_d     = 1'b0;
          chk_clear_c = 1'b1;
        end
      end
      S_WRITE: begin
        if (handshake_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_idx;
          mem_wdata_d = bus.cfg_data;
          count_d     = (count == FULL_COUNT) ? count : count + COUNT_ONE;
          if (wr_idx == LAST_ADDR) begin
            state_d = S_FLUSH;
          end else begin
            wr_idx_d = wr_idx + ADDR_ONE;
          end
        end
      end
      S_FLUSH: begin
        state_d    = S_READ;
        mem_re_d   = 1'b1;
        mem_addr_d = '0;
      end
      S_READ: begin
        if (mem_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          mem_re_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_ONE;
        end
      end
      // The final read beat is accumulated on the edge that leaves DRAIN
      S_DRAIN: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        error_d = (rd_chk != wr_chk);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state != S_IDLE)) begin
      state_d  = S_IDLE;
      mem_we_d = 1'b0;
      mem_re_d = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule
